seq_ack_receiver: RTL and testbench
===================================

# seq_ack_receiver

Downstream consumer of the test-bench sender in the feedback-handshake lab. Captures each 4-bit word announced by a one-cycle `en` pulse and checks it against the expected incrementing sequence. Buffers the word in a small FIFO for a ready/valid consumer, then returns a one-cycle `ack` pulse after a programmable delay. Withholding `ack` while the FIFO is full is the back-pressure path to the sender.

## Interface

Parameters:
- `DATA_W`, default 4, word width; must match the sender.
- `DEPTH`, default 4, FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all logic is posedge.
- `rst`  in  1  synchronous, active-high reset.
- `data`  in  DATA_W  word from the sender; valid only while `en`=1.
- `en`  in  1  one-cycle "word present" strobe.
- `ack`  out  1  one-cycle pulse: word accepted; sender may send the next one.
- `ack_delay`  in  8  extra cycles to hold off `ack`; sampled at capture.
- `out_data`  out  DATA_W  FIFO head.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer pop; a pop happens when `out_valid` & `out_ready`.
- `fifo_level`  out  clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `recv_count`  out  16  words captured; wraps modulo 2^16.
- `err_count`  out  8  sequence mismatches; saturates at 255.
- `viol_count`  out  8  `en` pulses seen while busy; saturates at 255.

## Operation

Reset values: `ack`=0, `out_valid`=0, `fifo_level`=0, all counters 0, expected word `exp`=1, state IDLE. Any captured word not yet pushed is discarded. Reset takes priority over every other event.

State machine:
- IDLE
  - `en`=1: latch `data` into the hold register and latch `ack_delay` into `cnt`.
  - Increment `recv_count`.
  - If `data` != `exp`, increment `err_count`.
  - Set `exp` <= `data`+1 mod 2^DATA_W. This resyncs to the received word even on mismatch.
  - Go to WAIT.
- WAIT
  - `cnt` != 0: decrement `cnt`.
  - `cnt` == 0 and FIFO not full: push the hold register, set `ack`<=1, go to IDLE.
  - `cnt` == 0 and FIFO full: stay in WAIT. No `ack` is issued, so the sender stalls.
- `en`=1 in WAIT: the word is dropped and `viol_count` increments (saturating). `exp`, `recv_count` and `err_count` are unchanged.

Other rules:
- `ack` is a registered pulse, high exactly one cycle per accepted word, never high twice in a row.
- Full test uses occupancy before the edge. A pop in the same cycle does not make room for a push in that cycle.
- FIFO is first-in first-out. `out_data` is the head and is stable while `out_valid`=1 and no pop occurs.
- Simultaneous push and pop with the FIFO neither empty nor full: level unchanged.
- Pop with `out_valid`=0 is ignored.
- `exp` wraps: after 15 the expected word is 0 (DATA_W=4).

## Timing

- `en` sampled high in IDLE at edge T, `ack_delay`=D, FIFO not full:
  - Push happens at edge T+1+D.
  - `ack` is high in the cycle between edges T+1+D and T+2+D.
  - `out_valid` rises in that same cycle when the FIFO was empty.
- Minimum en-to-ack latency is 1 cycle (D=0).
- If the FIFO is full when `cnt` reaches 0, push and `ack` occur one edge after the first cycle in which the pre-edge level is below DEPTH.
- `ack_delay` changes after capture have no effect on the pending word.
- The block is back in IDLE in the same cycle that `ack`=1, so a new `en` in that cycle is captured.

## Test plan

- **Basic sequence:** sender sends 1,2,3 with D=0 and `out_ready`=1. Expect `ack` one cycle after each `en`, `out_data` = 1,2,3 in order, `recv_count`=3, `err_count`=0.
- **Delay:** D=5, one word. Expect `ack` exactly 6 cycles after the `en` edge. A change of `ack_delay` to 0 during WAIT has no effect.
- **Back-pressure:** `out_ready`=0, 5 words with DEPTH=4.
  - Expect 4 `ack`s, `fifo_level`=4, 5th word held with no `ack`.
  - Raise `out_ready` for one cycle: the 5th word is pushed and its `ack` is issued one edge after the pop.
- **Mismatch and wrap:** drive 14,15,0,2. Expect 0 errors across the 15→0 wrap and exactly 1 error at word 2; `exp` becomes 3.
- **Violation:** a second `en` during WAIT with D=3. Expect `viol_count`=1, no extra FIFO entry, a single `ack`.
- **Reset mid-operation:** assert `rst` while in WAIT with 2 words buffered. Expect all outputs at reset values next cycle, no `ack`, and the next word checked against `exp`=1.

Source files
------------

// File: rtl/seq_ack_receiver.sv
// seq_ack_receiver
//   Consumer side of the feedback handshake. Each one-cycle `en` strobe
//   announces a word on `data`; the word is captured, checked against the
//   expected incrementing sequence, held for `ack_delay` cycles, pushed into
//   a small FIFO and acknowledged with a one-cycle `ack` pulse. While the
//   FIFO is full the held word waits and `ack` is withheld, which stalls the
//   sender.
//
// Ports
//   clk, rst      single clock, synchronous active-high reset
//   data, en      word from sender, qualified by one-cycle strobe
//   ack           registered one-cycle "word accepted" pulse
//   ack_delay     extra hold-off cycles, sampled when the word is captured
//   out_data      FIFO head
//   out_valid     FIFO not empty
//   out_ready     consumer pop (pop = out_valid & out_ready)
//   fifo_level    FIFO occupancy, 0..DEPTH
//   recv_count    words captured (wraps)
//   err_count     sequence mismatches (saturating)
//   viol_count    strobes seen while a word is still pending (saturating)

module seq_ack_receiver #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          data,
  input  logic                       en,
  output logic                       ack,
  input  logic [7:0]                 ack_delay,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [15:0]                recv_count,
  output logic [7:0]                 err_count,
  output logic [7:0]                 viol_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [DATA_W-1:0] WORD_ONE = DATA_W'(1);
  localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
  localparam logic [LW-1:0]     LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]     LVL_FULL = LW'(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state;
  logic [DATA_W-1:0]   hold;
  logic [DATA_W-1:0]   exp_word;
  logic [7:0]          cnt;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  logic full;
  logic push;
  logic pop;

  // Full is judged on the pre-edge level, so a same-cycle pop never makes
  // room for a push; the push lands one edge after the pop.
  assign full      = (fifo_level == LVL_FULL);
  assign push      = (state == S_WAIT) && (cnt == 8'd0) && !full;
  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  // Storage needs no reset: entries are only visible through fifo_level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      hold       <= '0;
      exp_word   <= WORD_ONE;
      cnt        <= '0;
      ack        <= 1'b0;
      recv_count <= '0;
      err_count  <= '0;
      viol_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      ack <= 1'b0;

      case (state)
        S_IDLE: begin
          if (en) begin
            hold       <= data;
            cnt        <= ack_delay;
            recv_count <= recv_count + 16'd1;
            if (data != exp_word && err_count != 8'hFF)
              err_count <= err_count + 8'd1;
            // Resync to whatever arrived so one bad word costs one error.
            exp_word   <= data + WORD_ONE;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A strobe here means the sender ignored the handshake; drop it.
          if (en && viol_count != 8'hFF)
            viol_count <= viol_count + 8'd1;
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (!full) begin
            ack   <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ack_receiver.sv
// Bench for seq_ack_receiver: directed stimulus, scoreboard queue of words
// expected out of the FIFO, and a negedge monitor that checks every pop and
// every ack pulse.

module tb_seq_ack_receiver;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DATA_W-1:0]      data;
  logic                   en;
  logic                   ack;
  logic [7:0]             ack_delay;
  logic [DATA_W-1:0]      out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [15:0]            recv_count;
  logic [7:0]             err_count;
  logic [7:0]             viol_count;

  seq_ack_receiver #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data(data), .en(en), .ack(ack),
    .ack_delay(ack_delay), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level), .recv_count(recv_count),
    .err_count(err_count), .viol_count(viol_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ack_total = 0;
  int recv_exp = 0;
  logic prev_ack = 1'b0;
  logic [DATA_W-1:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: every pop must match the scoreboard head; every ack must be a
  // single-cycle pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("fifo_unexpected_pop", 0, 1);
        else check("fifo_data", {28'd0, out_data}, {28'd0, sb_q.pop_front()});
      end
      if (ack) begin
        ack_total++;
        check("ack_single_cycle", {31'd0, prev_ack}, 0);
      end
    end
    prev_ack = ack;
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Strobe one word; returns just after the capture edge.
  task automatic send(input logic [DATA_W-1:0] w, input logic [7:0] d);
    data = w; ack_delay = d; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    recv_exp++;
    sb_q.push_back(w);
  endtask

  // Counts edges until ack is seen, bounded by max.
  task automatic wait_ack(input int max, output int n, output bit got);
    got = 1'b0; n = 0;
    while (n < max && !got) begin
      @(posedge clk); #1;
      n++;
      got = ack;
    end
  endtask

  initial begin
    int n;
    bit got;
    int acks_before;

    rst = 1'b1; en = 1'b0; data = '0; ack_delay = '0; out_ready = 1'b1;
    cycles(2);
    rst = 1'b0;

    // reset state
    check("rst_ack", ack, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_recv", recv_count, 0);
    check("rst_err", err_count, 0);
    check("rst_viol", viol_count, 0);

    // basic sequence 1,2,3 with zero delay
    for (int i = 1; i <= 3; i++) begin
      send(DATA_W'(i), 8'd0);
      wait_ack(4, n, got);
      check("basic_latency", got ? n : -1, 1);
    end
    cycles(2);
    check("basic_recv", recv_count, 3);
    check("basic_err", err_count, 0);
    check("basic_level", fifo_level, 0);

    // programmable delay; late change of ack_delay must not matter
    send(4'd4, 8'd5);
    ack_delay = 8'd0;
    wait_ack(12, n, got);
    check("delay_latency", got ? n : -1, 6);
    cycles(1);
    check("delay_err", err_count, 0);

    // back-pressure: consumer stalled, five words into a four-deep FIFO
    out_ready = 1'b0;
    cycles(1);
    for (int w = 5; w <= 8; w++) begin
      send(DATA_W'(w), 8'd0);
      wait_ack(4, n, got);
      check("bp_latency", got ? n : -1, 1);
    end
    check("bp_level_full", fifo_level, 4);
    check("bp_head", out_data, 5);
    send(4'd9, 8'd0);
    wait_ack(10, n, got);
    check("bp_no_ack_when_full", {31'd0, got}, 0);
    check("bp_level_held", fifo_level, 4);
    check("bp_head_stable", out_data, 5);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_ack(3, n, got);
    check("bp_ack_after_pop", got ? n : -1, 1);
    check("bp_level_refill", fifo_level, 4);
    check("bp_head_next", out_data, 6);
    out_ready = 1'b1;
    cycles(6);
    check("bp_drained", fifo_level, 0);

    // sequence through the 15->0 wrap, then one mismatch and resync
    for (int w = 10; w <= 16; w++) begin
      send(DATA_W'(w), 8'd0);
      wait_ack(4, n, got);
      check("wrap_latency", got ? n : -1, 1);
    end
    check("wrap_no_err", err_count, 0);
    send(4'd2, 8'd0);
    wait_ack(4, n, got);
    check("mismatch_err", err_count, 1);
    send(4'd3, 8'd0);
    wait_ack(4, n, got);
    check("resync_err", err_count, 1);
    cycles(2);

    // second strobe while waiting is a violation and is dropped
    acks_before = ack_total;
    send(4'd4, 8'd3);
    data = 4'd5; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    wait_ack(10, n, got);
    check("viol_latency", got ? n : -1, 3);
    cycles(4);
    check("viol_count", viol_count, 1);
    check("viol_single_ack", ack_total - acks_before, 1);
    check("viol_level", fifo_level, 0);
    check("viol_recv", recv_count, recv_exp);
    check("viol_err", err_count, 1);

    // reset while a word waits and two are buffered
    out_ready = 1'b0;
    send(4'd5, 8'd0);
    wait_ack(4, n, got);
    send(4'd6, 8'd0);
    wait_ack(4, n, got);
    check("prerst_level", fifo_level, 2);
    send(4'd7, 8'd10);
    cycles(2);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    recv_exp = 0;
    check("mrst_ack", ack, 0);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_level", fifo_level, 0);
    check("mrst_recv", recv_count, 0);
    check("mrst_err", err_count, 0);
    check("mrst_viol", viol_count, 0);
    acks_before = ack_total;
    cycles(12);
    check("mrst_no_ack", ack_total - acks_before, 0);
    out_ready = 1'b1;
    send(4'd1, 8'd0);
    wait_ack(4, n, got);
    check("mrst_latency", got ? n : -1, 1);
    cycles(2);
    check("mrst_exp_one", err_count, 0);
    check("mrst_recv_after", recv_count, recv_exp);
    check("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
